// File: rtl/ram_array_if.sv
// Request/response bundle for ram_array: the requester drives select/rdwr/addr/in,
// and the RAM returns out/out_valid/busy.
interface ram_array_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned ADDR_W = 2
);
  logic              select;
  logic              rdwr;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  in;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              busy;

  modport master (
    output select, rdwr, addr, in,
    input  out, out_valid, busy
  );

  modport slave (
    input  select, rdwr, addr, in,
    output out, out_valid, busy
  );
endinterface

// File: rtl/ram_array.sv
// Parametrised synchronous RAM: select/rdwr access, registered 1-cycle read with valid flag.
// Define RAM_CLEAR_EN to compile in the post-reset zero-fill sequencer (busy while clearing).
module ram_array #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input logic        clk,
  input logic        rst_n,
  ram_array_if.slave bus
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  logic [WIDTH-1:0]  out_d, out_q;
  logic              out_valid_d, out_valid_q;
  logic              in_range;
  logic              accept;

`ifdef RAM_CLEAR_EN
  typedef enum logic [0:0] {StClear, StIdle} state_e;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;

  assign accept   = (state_q == StIdle);
  assign bus.busy = (state_q == StClear);
`else
  assign accept   = 1'b1;
  assign bus.busy = 1'b0;
`endif

  // Addresses past DEPTH exist only for non-power-of-two depths.
  assign in_range = ({1'b0, bus.addr} < DepthW);

  always_comb begin
    mem_we      = 1'b0;
    mem_waddr   = bus.addr;
    mem_wdata   = bus.in;
    out_d       = '0;
    out_valid_d = 1'b0;
`ifdef RAM_CLEAR_EN
    state_d     = state_q;
    ptr_d       = ptr_q;
    if (state_q == StClear) begin
      mem_we    = 1'b1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
      ptr_d     = ptr_q + 1'b1;
      if (ptr_q == LastAddr) begin
        state_d = StIdle;
        ptr_d   = '0;
      end
    end
`endif
    if (accept && bus.select) begin
      if (bus.rdwr) begin
        out_valid_d = 1'b1;
        out_d       = in_range ? mem_q[bus.addr] : '0;
      end else begin
        mem_we = in_range;
      end
    end
  end

  // Storage array has no reset; only control and output registers do.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef RAM_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end
`endif

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_ram_array.sv
// Directed self-checking bench for ram_array: a DEPTH=4 and a DEPTH=5 instance on one clock.
// Clear-sequencer checks are compiled only when RAM_CLEAR_EN is defined.
module tb_ram_array;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ram_array_if #(.WIDTH(4), .ADDR_W(2)) bus4 ();
  ram_array_if #(.WIDTH(4), .ADDR_W(3)) bus5 ();

  ram_array #(.WIDTH(4), .DEPTH(4), .ADDR_W(2)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  ram_array #(.WIDTH(4), .DEPTH(5), .ADDR_W(3)) u_dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5.slave)
  );

`ifdef RAM_CLEAR_EN
  localparam logic ExpBusy = 1'b1;
`else
  localparam logic ExpBusy = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request on the DEPTH=4 bus; returns at edge + 1.
  task automatic op4(input logic sel, input logic rw, input logic [1:0] a, input logic [3:0] d);
    bus4.select = sel;
    bus4.rdwr   = rw;
    bus4.addr   = a;
    bus4.in     = d;
    bus5.select = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic op5(input logic sel, input logic rw, input logic [2:0] a, input logic [3:0] d);
    bus5.select = sel;
    bus5.rdwr   = rw;
    bus5.addr   = a;
    bus5.in     = d;
    bus4.select = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus4.select = 1'b0;
    bus4.rdwr   = 1'b0;
    bus4.addr   = '0;
    bus4.in     = '0;
    bus5.select = 1'b0;
    bus5.rdwr   = 1'b0;
    bus5.addr   = '0;
    bus5.in     = '0;
    #1;
    check_eq("rst_out", 8'(bus4.out), 8'h0);
    check_eq("rst_valid", 8'(bus4.out_valid), 8'h0);
    check_eq("rst_busy", 8'(bus4.busy), 8'(ExpBusy));
    @(posedge clk);
    @(posedge clk);
    #1;

`ifdef RAM_CLEAR_EN
    // Interrupt the clear after two words; it must restart from word 0.
    rst_n = 1'b1;
    op4(1'b0, 1'b0, 2'd0, 4'h0);
    op4(1'b0, 1'b0, 2'd0, 4'h0);
    check_eq("midclr_busy_before", 8'(bus4.busy), 8'h1);
    rst_n = 1'b0;
    #1;
    check_eq("midclr_busy_in_rst", 8'(bus4.busy), 8'h1);
    check_eq("midclr_valid_in_rst", 8'(bus4.out_valid), 8'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("clr_busy4_%0d", i), 8'(bus4.busy), (i < 4) ? 8'h1 : 8'h0);
      check_eq($sformatf("clr_busy5_%0d", i), 8'(bus5.busy), 8'h1);
      if (i == 1) op4(1'b1, 1'b0, 2'd3, 4'hF);
      else        op4(1'b0, 1'b0, 2'd0, 4'h0);
      check_eq($sformatf("clr_valid_%0d", i), 8'(bus4.out_valid), 8'h0);
    end
    check_eq("clr_busy5_done", 8'(bus5.busy), 8'h0);
    for (int a = 0; a < 4; a++) begin
      op4(1'b1, 1'b1, 2'(a), 4'h0);
      check_eq($sformatf("clr_rd_%0d", a), 8'(bus4.out), 8'h0);
      check_eq($sformatf("clr_rd_valid_%0d", a), 8'(bus4.out_valid), 8'h1);
    end
`else
    rst_n = 1'b1;
    check_eq("noclr_busy", 8'(bus4.busy), 8'h0);
    // Accepted on the very first edge after reset.
    op4(1'b1, 1'b0, 2'd0, 4'h3);
    op4(1'b1, 1'b1, 2'd0, 4'h0);
    check_eq("first_edge_rd", 8'(bus4.out), 8'h3);
`endif

    // Write then back-to-back reads.
    op4(1'b1, 1'b0, 2'd2, 4'hA);
    check_eq("wr_valid", 8'(bus4.out_valid), 8'h0);
    check_eq("wr_out", 8'(bus4.out), 8'h0);
    op4(1'b1, 1'b0, 2'd1, 4'h5);
    op4(1'b1, 1'b1, 2'd2, 4'h0);
    check_eq("rd2_out", 8'(bus4.out), 8'hA);
    check_eq("rd2_valid", 8'(bus4.out_valid), 8'h1);
    op4(1'b1, 1'b1, 2'd1, 4'h0);
    check_eq("rd1_out", 8'(bus4.out), 8'h5);
    check_eq("rd1_valid", 8'(bus4.out_valid), 8'h1);

    // Idle gating: output drops, unselected write has no effect.
    op4(1'b0, 1'b0, 2'd2, 4'hF);
    check_eq("idle_out", 8'(bus4.out), 8'h0);
    check_eq("idle_valid", 8'(bus4.out_valid), 8'h0);
    op4(1'b1, 1'b1, 2'd2, 4'h0);
    check_eq("idle_keep", 8'(bus4.out), 8'hA);

    // Read immediately after write to same address.
    op4(1'b1, 1'b0, 2'd3, 4'h9);
    op4(1'b1, 1'b1, 2'd3, 4'h0);
    check_eq("raw_out", 8'(bus4.out), 8'h9);

    // Non-power-of-two depth: out-of-range write dropped, read returns 0.
`ifdef RAM_CLEAR_EN
    op5(1'b1, 1'b1, 3'd4, 4'h0);
    check_eq("d5_rd4_clr", 8'(bus5.out), 8'h0);
`endif
    op5(1'b1, 1'b0, 3'd2, 4'h1);
    op5(1'b1, 1'b0, 3'd6, 4'h7);
    op5(1'b1, 1'b1, 3'd6, 4'h0);
    check_eq("d5_rd6_out", 8'(bus5.out), 8'h0);
    check_eq("d5_rd6_valid", 8'(bus5.out_valid), 8'h1);
    op5(1'b1, 1'b1, 3'd2, 4'h0);
    check_eq("d5_rd2_alias", 8'(bus5.out), 8'h1);
    op5(1'b1, 1'b0, 3'd4, 4'hC);
    op5(1'b1, 1'b1, 3'd4, 4'h0);
    check_eq("d5_rd4", 8'(bus5.out), 8'hC);

    // Asynchronous reset while a read result is presented.
    op4(1'b1, 1'b1, 2'd2, 4'h0);
    check_eq("pre_rst_valid", 8'(bus4.out_valid), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out", 8'(bus4.out), 8'h0);
    check_eq("async_rst_valid", 8'(bus4.out_valid), 8'h0);
    check_eq("async_rst_busy", 8'(bus4.busy), 8'(ExpBusy));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op4(1'b0, 1'b0, 2'd0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_array.md
# ram_array

Parametrised synchronous RAM: the multi-word, multi-bit successor to the single-bit binary RAM cell. Keeps the cell's select/rdwr access convention: `rdwr`=1 reads, `rdwr`=0 writes, and `out` is zero unless a read is being presented. Adds addressing, registered one-cycle read latency with a valid flag, and an optional post-reset clear sequencer. It is the storage building block for the RAM assignments and any register-file style structure above it.

## Interface
- `WIDTH`, default 4: data bits per word; ≥1.
- `DEPTH`, default 4: number of words; ≥2.
- `ADDR_W`, default 2: address bits; equals ceil(log2(DEPTH)), set by the instantiator.
- `clk`: input, 1 bit. Single clock; all state changes on its rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `select`: input, 1 bit. Access request, sampled at the rising edge.
- `rdwr`: input, 1 bit. 1 = read, 0 = write; meaningful only when `select`=1.
- `addr`: input, `ADDR_W` bits. Word address.
- `in`: input, `WIDTH` bits. Write data.
- `out`: output, `WIDTH` bits. Read data; zero whenever `out_valid`=0.
- `out_valid`: output, 1 bit. `out` carries read data this cycle.
- `busy`: output, 1 bit. Clear sequence in progress; all requests are ignored.

## Operation
- Storage: `DEPTH` × `WIDTH` array. The array itself is not asynchronously reset; only control and output registers are.
- States: CLEAR and IDLE.
- CLEAR (only with `RAM_CLEAR_EN`):
  - A clear pointer starts at 0 and writes zero to word[ptr] each cycle, then increments.
  - After word `DEPTH`-1 is written, the next state is IDLE.
  - `busy`=1 throughout. `select` is ignored; no read or write takes effect, and `out_valid` stays 0.
- IDLE:
  - Write, `select`=1 and `rdwr`=0: word[addr] ← `in` at the edge. `out_valid` is 0 next cycle.
  - Read, `select`=1 and `rdwr`=1: `out` ← word[addr] and `out_valid` ← 1 at the edge.
  - No request, `select`=0: `out_valid` ← 0 and `out` ← 0. The last read value is not held.
- Out-of-range address (`addr` ≥ `DEPTH`, non-power-of-two depth):
  - Write: discarded.
  - Read: returns 0 with `out_valid`=1.
- Back-to-back requests: accepted every cycle. A read immediately after a write to the same address returns the new data.
- Reset mid-operation:
  - `rst_n` low at any time forces `out`=0, `out_valid`=0 and the clear pointer to 0 immediately.
  - With `RAM_CLEAR_EN`: state CLEAR, `busy`=1. A clear interrupted by reset restarts from word 0.
  - Without `RAM_CLEAR_EN`: state IDLE, `busy`=0.

## Timing
- Read latency: 1 cycle. A request sampled at edge N gives data and `out_valid` valid after edge N, held until edge N+1.
- Write: effective at the sampling edge; readable by a request at the next edge.
- Clear duration: exactly `DEPTH` cycles after `rst_n` rises. The first rising edge with `rst_n`=1 clears word 0. `busy` falls after the edge that clears word `DEPTH`-1.
- Reset values:
  - `out` = 0, `out_valid` = 0.
  - `busy` = 1 with `RAM_CLEAR_EN`, 0 without.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `RAM_CLEAR_EN` defined:
  - The CLEAR state and clear pointer are compiled in.
  - After every reset the memory reads all-zero, and `busy` behaves as described above.
- `RAM_CLEAR_EN` undefined:
  - No sequencer; `busy` is tied to 0.
  - The block accepts requests on the first edge after reset.
  - Unwritten words read X in simulation and are undefined in hardware.

## Test plan
- Reset clear (`RAM_CLEAR_EN`, WIDTH=4, DEPTH=4): release `rst_n` → `busy`=1 for exactly 4 cycles. A read of each address then returns 4'h0 with `out_valid`=1.
- Write then read: write 4'hA to addr 2 and 4'h5 to addr 1, then read 2 and 1 back-to-back → `out` = 4'hA, then 4'h5, each one cycle after its request.
- Idle gating: after a read returns 4'hA, drop `select` → next cycle `out`=4'h0 and `out_valid`=0. A write with `select`=0 leaves memory unchanged.
- Busy ignore: during CLEAR, issue a write of 4'hF to addr 3 → ignored; addr 3 later reads 4'h0.
- Reset mid-clear: assert `rst_n` low after 2 clear cycles, then release → `busy` lasts a full 4 cycles again. `out` and `out_valid` go to 0 asynchronously while `rst_n` is low.
- Non-power-of-two (DEPTH=5, ADDR_W=3): write 4'h7 to addr 6 → discarded. A read of addr 6 returns 4'h0 with `out_valid`=1, and addr 4 still reads 4'h0.
